// File: rtl/endstop_capture.sv
// Endstop capture stage: arms on host command, latches the trigger position from a locked
// debouncer, and owns its unlock pulse. Define ENDSTOP_CAPTURE_BOUNCE_STATS_EN for chatter stats.
module endstop_capture #(
    parameter int CNT_W   = 32,
    parameter int STRAY_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arm,
    input  logic               abort,
    input  logic               ack,
    input  logic               trigger_level,
    input  logic [CNT_W-1:0]   timeout,
    input  logic               sig_out,
    input  logic               sig_changed,
    input  logic [31:0]        pos_out,
    input  logic [31:0]        pos_in,
`ifdef ENDSTOP_CAPTURE_BOUNCE_STATS_EN
    input  logic [7:0]         cycles,
`endif
    output logic               unlock,
    output logic               stop_req,
    output logic               busy,
    output logic               done,
    output logic               timed_out,
    output logic               pre_triggered,
    output logic [31:0]        captured_pos,
    output logic [STRAY_W-1:0] stray_events,
    output logic               irq,
    output logic [7:0]         bounce_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMING,
        S_ARMED,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t             state_q;
    logic               unlock_q;
    logic               stop_req_q;
    logic               busy_q;
    logic               done_q;
    logic               timed_out_q;
    logic               pre_triggered_q;
    logic [31:0]        captured_pos_q;
    logic [STRAY_W-1:0] stray_q;
    logic               irq_q;
    logic [CNT_W-1:0]   wd_q;
`ifdef ENDSTOP_CAPTURE_BOUNCE_STATS_EN
    logic [7:0]         bounce_q;
    logic [7:0]         cycles_base_q;
`endif

    logic trig_match_d;
    logic wd_expire_d;
    logic stray_full_d;

    assign trig_match_d = (sig_out == trigger_level);
    // Expires on the ARMED cycle whose count is timeout-1, so timeout=1 fires on the first one.
    assign wd_expire_d  = (timeout != '0) && (wd_q == timeout - CNT_W'(1));
    assign stray_full_d = (stray_q == {STRAY_W{1'b1}});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            unlock_q        <= 1'b0;
            stop_req_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            timed_out_q     <= 1'b0;
            pre_triggered_q <= 1'b0;
            captured_pos_q  <= '0;
            stray_q         <= '0;
            irq_q           <= 1'b0;
            wd_q            <= '0;
`ifdef ENDSTOP_CAPTURE_BOUNCE_STATS_EN
            bounce_q        <= '0;
            cycles_base_q   <= '0;
`endif
        end else begin
            unlock_q <= 1'b0;
            irq_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        // Outputs of ARMING are registered on entry so unlock lands during ARMING.
                        state_q         <= S_ARMING;
                        busy_q          <= 1'b1;
                        unlock_q        <= 1'b1;
                        stray_q         <= '0;
                        wd_q            <= '0;
                        done_q          <= 1'b0;
                        timed_out_q     <= 1'b0;
                        pre_triggered_q <= 1'b0;
`ifdef ENDSTOP_CAPTURE_BOUNCE_STATS_EN
                        bounce_q        <= '0;
`endif
                    end else if (sig_changed) begin
                        unlock_q <= 1'b1;
                    end
                end
                S_ARMING: begin
                    if (abort) begin
                        state_q    <= S_RELEASE;
                        unlock_q   <= 1'b1;
                        stop_req_q <= 1'b0;
                        done_q     <= 1'b0;
                    end else if (trig_match_d) begin
                        state_q         <= S_DONE;
                        captured_pos_q  <= pos_in;
                        pre_triggered_q <= 1'b1;
                        stop_req_q      <= 1'b1;
                        done_q          <= 1'b1;
                        irq_q           <= 1'b1;
`ifdef ENDSTOP_CAPTURE_BOUNCE_STATS_EN
                        cycles_base_q   <= cycles;
`endif
                    end else begin
                        state_q <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    wd_q <= wd_q + CNT_W'(1);
                    if (abort) begin
                        state_q    <= S_RELEASE;
                        unlock_q   <= 1'b1;
                        stop_req_q <= 1'b0;
                        done_q     <= 1'b0;
                    end else if (sig_changed && trig_match_d) begin
                        // Debouncer stays locked so pos_out remains the frozen trigger point.
                        state_q        <= S_DONE;
                        captured_pos_q <= pos_out;
                        stop_req_q     <= 1'b1;
                        done_q         <= 1'b1;
                        irq_q          <= 1'b1;
`ifdef ENDSTOP_CAPTURE_BOUNCE_STATS_EN
                        cycles_base_q  <= cycles;
`endif
                    end else if (sig_changed) begin
                        unlock_q <= 1'b1;
                        if (!stray_full_d) begin
                            stray_q <= stray_q + STRAY_W'(1);
                        end
                    end else if (wd_expire_d) begin
                        state_q        <= S_DONE;
                        timed_out_q    <= 1'b1;
                        captured_pos_q <= pos_in;
                        stop_req_q     <= 1'b1;
                        done_q         <= 1'b1;
                        irq_q          <= 1'b1;
                    end
                end
                S_DONE: begin
`ifdef ENDSTOP_CAPTURE_BOUNCE_STATS_EN
                    bounce_q <= cycles - cycles_base_q;
`endif
                    if (ack || abort) begin
                        state_q    <= S_RELEASE;
                        unlock_q   <= 1'b1;
                        stop_req_q <= 1'b0;
                        done_q     <= 1'b0;
                    end
                end
                S_RELEASE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign unlock        = unlock_q;
    assign stop_req      = stop_req_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign timed_out     = timed_out_q;
    assign pre_triggered = pre_triggered_q;
    assign captured_pos  = captured_pos_q;
    assign stray_events  = stray_q;
    assign irq           = irq_q;
`ifdef ENDSTOP_CAPTURE_BOUNCE_STATS_EN
    assign bounce_cycles = bounce_q;
`else
    assign bounce_cycles = '0;
`endif

endmodule

// File: doc/endstop_capture.md
Name: endstop_capture

Overview:
- Consumer stage placed directly downstream of each axis endstop debouncer.
- Arms on host command and watches the debouncer's locked event outputs (sig_out, sig_changed, pos_out).
- On the trigger edge it latches the trigger position, raises a stop request to the motion core, and holds until the host acks.
- Owns the debouncer's unlock pulse, so the debouncer never stays locked unattended.

Parameters:
- CNT_W, 32, width of the arm watchdog counter and the timeout input.
- STRAY_W, 8, width of the stray-event counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- arm  in  1  1-cycle pulse; start a capture.
- abort  in  1  1-cycle pulse; cancel any capture.
- ack  in  1  1-cycle pulse; host has read the result; release.
- trigger_level  in  1  sig_out level that counts as trigger.
- timeout  in  CNT_W  max ARMED cycles; 0 = no watchdog.
- sig_out  in  1  debounced level from debouncer.
- sig_changed  in  1  debouncer locked-event flag.
- pos_out  in  32  debouncer-latched position at bounce start.
- pos_in  in  32  live axis position (same bus fed to debouncer).
- unlock  out  1  1-cycle pulse to debouncer.
- stop_req  out  1  motion stop request, level.
- busy  out  1  state != IDLE.
- done  out  1  capture finished; valid until ack/abort.
- timed_out  out  1  done by watchdog, no trigger.
- pre_triggered  out  1  sig_out already at trigger_level when armed.
- captured_pos  out  32  trigger position.
- stray_events  out  STRAY_W  unwanted events seen while ARMED, saturating.
- irq  out  1  1-cycle pulse on entry to DONE.
- bounce_cycles  out  8  see Optional Feature.

Behaviour:
- Reset (reset=0, async), all outputs 0:
  - state=IDLE.
  - unlock, stop_req, busy, done, timed_out, pre_triggered, irq = 0.
  - captured_pos=0, stray_events=0, bounce_cycles=0, watchdog=0.
- All outputs are registered. unlock and irq are high for exactly one cycle per event.

States: IDLE, ARMING, ARMED, DONE, RELEASE.

IDLE:
- sig_changed=1 -> pulse unlock. Auto-clear so the debouncer keeps tracking.
- arm -> ARMING.
- abort ignored.

ARMING (exactly 1 cycle):
- unlock=1, stray_events=0, watchdog=0, done=0, timed_out=0, pre_triggered=0.
- If sig_out==trigger_level: captured_pos<=pos_in, pre_triggered<=1, stop_req<=1, irq, -> DONE.
- Otherwise -> ARMED.
- Because unlock is registered, sig_changed is already 0 on the first ARMED cycle.

ARMED:
- watchdog increments each cycle.
- Priority: abort > trigger > stray > timeout.
- Trigger (sig_changed=1 and sig_out==trigger_level):
  - captured_pos<=pos_out, stop_req<=1, irq.
  - Do NOT unlock (debouncer stays locked, pos_out frozen).
  - -> DONE.
- Stray (sig_changed=1 and sig_out!=trigger_level):
  - stray_events+1, saturating at all-ones.
  - unlock pulse, stay ARMED.
- Timeout (timeout!=0 and watchdog==timeout-1 on this cycle with no trigger):
  - timed_out<=1, stop_req<=1, captured_pos<=pos_in, irq.
  - -> DONE.
  - timeout=1 therefore expires on the first ARMED cycle.
- Trigger and timeout in the same cycle: trigger wins, timed_out=0.

DONE:
- done=1; stop_req held.
- ack or abort -> RELEASE.
- arm ignored.

RELEASE (exactly 1 cycle):
- unlock=1, stop_req<=0, done<=0, -> IDLE.
- captured_pos, timed_out, pre_triggered and stray_events hold until the next ARMING.

Abort from ARMING or ARMED:
- -> RELEASE; no irq.
- captured_pos unchanged.

Reset mid-capture:
- stop_req drops asynchronously.
- No unlock is issued. The debouncer is reset by the same system reset.

Optional Feature:
- Macro: ENDSTOP_CAPTURE_BOUNCE_STATS_EN.
- Defined:
  - On trigger entry to DONE, latch cycles_base<=cycles. This requires an extra input port cycles[7:0], the debouncer event counter, present only when the macro is defined.
  - While in DONE, bounce_cycles<=cycles-cycles_base, modulo 256. This measures endstop chatter while locked.
  - Reset to 0 in ARMING.
- Undefined: bounce_cycles tied to 0; no cycles port; no extra registers.

Test Plan:
- Reset released, arm; at cycle 20 drive sig_changed=1, sig_out=1, trigger_level=1, pos_out=0x1234 -> next cycle stop_req=1, captured_pos=0x1234, irq one cycle, unlock stays 0. ack -> one unlock pulse, stop_req=0, busy=0 next cycle.
- trigger_level=1, arm while sig_out=1, pos_in=500 -> two cycles after arm: done=1, pre_triggered=1, captured_pos=500, stop_req=1.
- Armed, timeout=100, no events -> stop_req=1, timed_out=1 exactly 100 cycles after ARMED entry; captured_pos=pos_in at that cycle.
- Armed, trigger_level=1, three sig_changed events with sig_out=0, then one with sig_out=1 -> three unlock pulses, stray_events=3, then trigger capture. Trigger coinciding with timeout expiry -> timed_out=0.
- Armed, abort -> RELEASE then IDLE, unlock one cycle, no irq. Separately, assert reset while in DONE -> stop_req=0 immediately (before next clk), all outputs 0.
- With ENDSTOP_CAPTURE_BOUNCE_STATS_EN: trigger with cycles=250, then cycles steps to 251, 252, 3 while in DONE -> bounce_cycles=9. Without the macro -> bounce_cycles=0 throughout.
